// File: rtl/sha512_stream_ctrl.sv
// Purpose: packs a 64-bit big-endian message stream into padded 1024-bit SHA-512 blocks, sequences the core and returns the digest.
// Latency: one word per cycle in FILL; padding one word per cycle (length words in one); the digest appears one cycle after the final block completes.
// Backpressure: s_ready_o is low outside FILL; launches wait for core_idle_i && !core_hold_i; the digest is held until dig_ready_i.
module sha512_stream_ctrl #(
    parameter int DataWidth   = 64,
    parameter int BlockWidth  = 1024,
    parameter int DigestWidth = 512
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [DataWidth-1:0]   s_data_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic                   s_last_i,
    input  logic [3:0]             s_bytes_i,
    output logic [BlockWidth-1:0]  core_block_o,
    output logic                   core_enable_o,
    output logic                   core_rst_o,
    input  logic                   core_hold_i,
    input  logic                   core_idle_i,
    input  logic [DigestWidth-1:0] core_digest_i,
    input  logic                   core_digest_valid_i,
    output logic [DigestWidth-1:0] dig_data_o,
    output logic                   dig_valid_o,
    input  logic                   dig_ready_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_PAD    = 3'd2;
    localparam logic [2:0] S_LAUNCH = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]             state;
    logic [BlockWidth-1:0]  blk;
    logic [3:0]             idx;
    logic [63:0]            cnt;
    logic                   marker_done;
    logic                   len_pending;
    logic                   msg_done;     // final stream word has been taken
    logic [DigestWidth-1:0] dig_q;

    logic [63:0] last_word;
    logic [63:0] word_in;
    logic [63:0] add_bytes;
    logic [9:0]  word_lsb;                // bit offset of word idx inside the block

    // Final word: clear bytes past the valid count and drop the 0x80 marker right after them.
    always_comb begin
        last_word = s_data_i;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) >= s_bytes_i) begin
                last_word[63-8*b -: 8] = 8'h00;
            end
            if (4'(b) == s_bytes_i) begin
                last_word[63-8*b -: 8] = 8'h80;
            end
        end
    end

    assign word_in   = s_last_i ? last_word : s_data_i;
    assign add_bytes = s_last_i ? {60'd0, s_bytes_i} : 64'd8;
    assign word_lsb  = {~idx, 6'd0};

    // Message sequencer: fill, pad, launch, wait for the core, hand off the digest.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            blk         <= '0;
            idx         <= 4'd0;
            cnt         <= 64'd0;
            marker_done <= 1'b0;
            len_pending <= 1'b0;
            msg_done    <= 1'b0;
            dig_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_valid_i) begin
                        idx         <= 4'd0;
                        cnt         <= 64'd0;
                        marker_done <= 1'b0;
                        len_pending <= 1'b0;
                        msg_done    <= 1'b0;
                        state       <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (s_valid_i) begin
                        blk[word_lsb +: 64] <= word_in;
                        idx                 <= idx + 4'd1;
                        cnt                 <= cnt + add_bytes;
                        if (s_last_i) begin
                            msg_done <= 1'b1;
                            if (s_bytes_i < 4'd8) begin
                                marker_done <= 1'b1;
                            end
                            if (idx == 4'd15) begin
                                len_pending <= 1'b1;
                                state       <= S_LAUNCH;
                            end else begin
                                state <= S_PAD;
                            end
                        end else if (idx == 4'd15) begin
                            state <= S_LAUNCH;
                        end
                    end
                end
                S_PAD: begin
                    if (idx == 4'd14 && marker_done) begin
                        // Bit length fills words 14-15 in a single cycle.
                        blk[127:0]  <= {61'd0, cnt, 3'b000};
                        len_pending <= 1'b0;
                        state       <= S_LAUNCH;
                    end else begin
                        blk[word_lsb +: 64] <= marker_done ? 64'd0 : {8'h80, 56'd0};
                        marker_done         <= 1'b1;
                        idx                 <= idx + 4'd1;
                        if (idx == 4'd15) begin
                            // No room for the length: it goes into an extra block.
                            len_pending <= 1'b1;
                            state       <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (core_idle_i && !core_hold_i) begin
                        idx   <= 4'd0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (core_digest_valid_i) begin
                        if (!msg_done) begin
                            state <= S_FILL;
                        end else if (len_pending || !marker_done) begin
                            state <= S_PAD;
                        end else begin
                            dig_q <= core_digest_i;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (dig_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign s_ready_o     = (state == S_FILL);
    assign core_rst_o    = (state == S_IDLE) && s_valid_i;
    assign core_enable_o = (state == S_LAUNCH) && core_idle_i && !core_hold_i;
    assign core_block_o  = blk;
    assign dig_valid_o   = (state == S_DONE);
    assign dig_data_o    = dig_q;

endmodule
